// File: rtl/tcam_lookup_engine_if.sv
// -----------------------------------------------------------------------------
// tcam_lookup_engine_if
//
// Purpose: groups the command and response handshakes of the TCAM lookup
// engine into one bundle.
//
// Parameters: KEY_W (key/mask width), RES_W (result width), ADDR_W (entry
// index width; must equal the engine's $clog2(DEPTH)).
//
// Signals:
//   cmd_valid/cmd_ready   command handshake (master -> engine)
//   cmd_op/addr/key/mask/result  command payload
//   rsp_valid/rsp_ready   response handshake (engine -> master)
//   rsp_op/err/hit/multi/index/key/mask/result/entry_valid  response payload
//
// Modports: master = command source / response sink, slave = engine.
// -----------------------------------------------------------------------------
interface tcam_lookup_engine_if #(
    parameter int KEY_W  = 8,
    parameter int RES_W  = 4,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [KEY_W-1:0]  cmd_key;
    logic [KEY_W-1:0]  cmd_mask;
    logic [RES_W-1:0]  cmd_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_op;
    logic              rsp_err;
    logic              rsp_hit;
    logic              rsp_multi;
    logic [ADDR_W-1:0] rsp_index;
    logic [KEY_W-1:0]  rsp_key;
    logic [KEY_W-1:0]  rsp_mask;
    logic [RES_W-1:0]  rsp_result;
    logic              rsp_entry_valid;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_result,
        input  cmd_ready,
        input  rsp_valid, rsp_op, rsp_err, rsp_hit, rsp_multi, rsp_index,
               rsp_key, rsp_mask, rsp_result, rsp_entry_valid,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_result,
        output cmd_ready,
        output rsp_valid, rsp_op, rsp_err, rsp_hit, rsp_multi, rsp_index,
               rsp_key, rsp_mask, rsp_result, rsp_entry_valid,
        input  rsp_ready
    );
endinterface

// File: rtl/tcam_lookup_engine.sv
// -----------------------------------------------------------------------------
// tcam_lookup_engine
//
// Purpose: parametrised ternary-CAM lookup engine. Each entry holds a key, a
// care mask and an associated result (destination ID). Commands arrive on a
// valid/ready handshake, run through a three-state FSM (IDLE, EXEC, RESP) and
// produce exactly one response, held until the consumer accepts it.
// COMPARE priority-encodes all matching entries (lowest index wins) and
// reports multi-hits.
//
// Parameters: KEY_W, RES_W, DEPTH (>= 2, any value), ADDR_W (derived from
// DEPTH; leave at default).
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          tcam_lookup_engine_if.slave (command + response channels)
//   stat_hits    (TCAM_HIT_STATS_EN only) saturating COMPARE hit counter
//   stat_misses  (TCAM_HIT_STATS_EN only) saturating COMPARE miss counter
//
// Optional feature macro: TCAM_HIT_STATS_EN adds the two statistics counters;
// both clear on rst and on FLUSH.
// -----------------------------------------------------------------------------
module tcam_lookup_engine #(
    parameter int KEY_W  = 8,
    parameter int RES_W  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    tcam_lookup_engine_if.slave  bus
`ifdef TCAM_HIT_STATS_EN
    ,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_misses
`endif
);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_WRITE   = 3'b001;
    localparam logic [2:0] OP_READ    = 3'b010;
    localparam logic [2:0] OP_FLUSH   = 3'b011;
    localparam logic [2:0] OP_COMPARE = 3'b100;
    localparam logic [2:0] OP_INVAL   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    // ---------------------------------------------------------------------
    // Latched command
    // ---------------------------------------------------------------------
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [KEY_W-1:0]  key_q;
    logic [KEY_W-1:0]  mask_q;
    logic [RES_W-1:0]  result_q;

    logic cmd_accept;

    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_NOP;
            addr_q   <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
        end else if (cmd_accept) begin
            op_q     <= bus.cmd_op;
            addr_q   <= bus.cmd_addr;
            key_q    <= bus.cmd_key;
            mask_q   <= bus.cmd_mask;
            result_q <= bus.cmd_result;
        end
    end

    // ---------------------------------------------------------------------
    // Entry storage. Valid bits are reset; payload arrays are not, since a
    // never-written entry is never reported as a match.
    // ---------------------------------------------------------------------
    logic [KEY_W-1:0] key_mem  [DEPTH];
    logic [KEY_W-1:0] mask_mem [DEPTH];
    logic [RES_W-1:0] res_mem  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    // ---------------------------------------------------------------------
    // Command decode (meaningful only while in EXEC)
    // ---------------------------------------------------------------------
    logic op_legal;
    logic op_uses_addr;
    logic addr_oob;
    logic exec_err;
    logic in_exec;
    logic mem_wr_en;

    assign op_legal     = (op_q <= OP_INVAL);
    assign op_uses_addr = (op_q == OP_WRITE) || (op_q == OP_READ) || (op_q == OP_INVAL);
    assign addr_oob     = (32'(addr_q) >= DEPTH);
    assign exec_err     = !op_legal || (op_uses_addr && addr_oob);
    assign in_exec      = (state_q == ST_EXEC);
    // Writes commit on the EXEC->RESP edge; a reset landing on that edge
    // drops the command entirely.
    assign mem_wr_en    = in_exec && (op_q == OP_WRITE) && !exec_err && !rst;

    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            // Don't-care bits are stored as zero so READ returns a clean key.
            key_mem[addr_q]  <= key_q & mask_q;
            mask_mem[addr_q] <= mask_q;
            res_mem[addr_q]  <= result_q;
        end
    end

    // ---------------------------------------------------------------------
    // Parallel match: an entry matches when every bit that both the entry
    // mask and the search mask care about agrees with the search key.
    // ---------------------------------------------------------------------
    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_q[gi] &&
                (((key_q ^ key_mem[gi]) & mask_mem[gi] & mask_q) == '0);
        end
    endgenerate

    // Priority encoder: the first match sets hit/index, any further match
    // marks the lookup as a multi-hit.
    logic              cmp_hit;
    logic              cmp_multi;
    logic [ADDR_W-1:0] cmp_idx;

    always_comb begin
        cmp_hit   = 1'b0;
        cmp_multi = 1'b0;
        cmp_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                if (cmp_hit) begin
                    cmp_multi = 1'b1;
                end else begin
                    cmp_hit = 1'b1;
                    cmp_idx = ADDR_W'(i);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response registers
    // ---------------------------------------------------------------------
    logic [2:0]        rsp_op_q,     rsp_op_d;
    logic              rsp_err_q,    rsp_err_d;
    logic              rsp_hit_q,    rsp_hit_d;
    logic              rsp_multi_q,  rsp_multi_d;
    logic [ADDR_W-1:0] rsp_index_q,  rsp_index_d;
    logic [KEY_W-1:0]  rsp_key_q,    rsp_key_d;
    logic [KEY_W-1:0]  rsp_mask_q,   rsp_mask_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_ev_q,     rsp_ev_d;

    // ---------------------------------------------------------------------
    // FSM next-state, response capture and valid-bit updates
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_multi_d  = rsp_multi_q;
        rsp_index_d  = rsp_index_q;
        rsp_key_d    = rsp_key_q;
        rsp_mask_d   = rsp_mask_q;
        rsp_result_d = rsp_result_q;
        rsp_ev_d     = rsp_ev_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d      = ST_RESP;
                // Every field not explicitly filled below reads as zero.
                rsp_op_d     = op_q;
                rsp_err_d    = exec_err;
                rsp_hit_d    = 1'b0;
                rsp_multi_d  = 1'b0;
                rsp_index_d  = '0;
                rsp_key_d    = '0;
                rsp_mask_d   = '0;
                rsp_result_d = '0;
                rsp_ev_d     = 1'b0;
                if (!exec_err) begin
                    case (op_q)
                        OP_WRITE: valid_d[addr_q] = 1'b1;
                        OP_INVAL: valid_d[addr_q] = 1'b0;
                        OP_FLUSH: valid_d         = '0;
                        OP_READ: begin
                            rsp_index_d  = addr_q;
                            rsp_key_d    = key_mem[addr_q];
                            rsp_mask_d   = mask_mem[addr_q];
                            rsp_result_d = res_mem[addr_q];
                            rsp_ev_d     = valid_q[addr_q];
                        end
                        OP_COMPARE: begin
                            rsp_hit_d    = cmp_hit;
                            rsp_multi_d  = cmp_multi;
                            rsp_index_d  = cmp_idx;
                            rsp_result_d = cmp_hit ? res_mem[cmp_idx] : '0;
                        end
                        default: ;  // NOP: all-zero response
                    endcase
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_multi_q  <= 1'b0;
            rsp_index_q  <= '0;
            rsp_key_q    <= '0;
            rsp_mask_q   <= '0;
            rsp_result_q <= '0;
            rsp_ev_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_multi_q  <= rsp_multi_d;
            rsp_index_q  <= rsp_index_d;
            rsp_key_q    <= rsp_key_d;
            rsp_mask_q   <= rsp_mask_d;
            rsp_result_q <= rsp_result_d;
            rsp_ev_q     <= rsp_ev_d;
        end
    end

    assign bus.rsp_valid       = (state_q == ST_RESP);
    assign bus.rsp_op          = rsp_op_q;
    assign bus.rsp_err         = rsp_err_q;
    assign bus.rsp_hit         = rsp_hit_q;
    assign bus.rsp_multi       = rsp_multi_q;
    assign bus.rsp_index       = rsp_index_q;
    assign bus.rsp_key         = rsp_key_q;
    assign bus.rsp_mask        = rsp_mask_q;
    assign bus.rsp_result      = rsp_result_q;
    assign bus.rsp_entry_valid = rsp_ev_q;

`ifdef TCAM_HIT_STATS_EN
    // ---------------------------------------------------------------------
    // Lookup statistics: every executed COMPARE bumps exactly one counter,
    // saturating at all-ones.
    // ---------------------------------------------------------------------
    logic [15:0] stat_hits_q,   stat_hits_d;
    logic [15:0] stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (in_exec && !exec_err) begin
            if (op_q == OP_FLUSH) begin
                stat_hits_d   = '0;
                stat_misses_d = '0;
            end else if (op_q == OP_COMPARE) begin
                if (cmp_hit) begin
                    if (stat_hits_q != 16'hFFFF) stat_hits_d = stat_hits_q + 16'd1;
                end else begin
                    if (stat_misses_q != 16'hFFFF) stat_misses_d = stat_misses_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// -----------------------------------------------------------------------------
// tb_tcam_lookup_engine
//
// Self-checking bench for tcam_lookup_engine (DEPTH=12, so out-of-range
// addresses 12..15 are reachable). Directed scenarios followed by random
// commands, all checked against a behavioural table model of the TCAM.
// Build with +define+TCAM_HIT_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tcam_lookup_engine;

    localparam int KEY_W  = 8;
    localparam int RES_W  = 4;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [2:0] OP_NOP = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2,
                           OP_FLUSH = 3'd3, OP_CMP = 3'd4, OP_INV = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcam_lookup_engine_if #(.KEY_W(KEY_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

`ifdef TCAM_HIT_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    tcam_lookup_engine #(.KEY_W(KEY_W), .RES_W(RES_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TCAM_HIT_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_key   [DEPTH];
    logic [7:0] m_mask  [DEPTH];
    logic [3:0] m_res   [DEPTH];
    bit         m_valid [DEPTH];
    bit         m_known [DEPTH];
    int         m_hits, m_misses;

    // expected response
    logic [2:0] e_op;
    bit         e_err, e_hit, e_multi, e_ev, e_dc;
    int         e_index;
    logic [7:0] e_key, e_mask;
    logic [3:0] e_res;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_known[i] = 0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_exec(input logic [2:0] op, input int addr, input logic [7:0] key,
                              input logic [7:0] mask, input logic [3:0] res);
        int hits_found;
        bit uses_addr;
        e_op = op; e_err = 0; e_hit = 0; e_multi = 0; e_ev = 0; e_dc = 0;
        e_index = 0; e_key = 0; e_mask = 0; e_res = 0;
        uses_addr = (op == OP_WRITE) || (op == OP_READ) || (op == OP_INV);
        if (op > OP_INV || (uses_addr && addr >= DEPTH)) begin
            e_err = 1;
            return;
        end
        case (op)
            OP_WRITE: begin
                m_key[addr]   = key & mask;
                m_mask[addr]  = mask;
                m_res[addr]   = res;
                m_valid[addr] = 1;
                m_known[addr] = 1;
            end
            OP_READ: begin
                e_index = addr;
                e_ev    = m_valid[addr];
                if (m_known[addr]) begin
                    e_key = m_key[addr]; e_mask = m_mask[addr]; e_res = m_res[addr];
                end else begin
                    e_dc = 1;
                end
            end
            OP_INV: m_valid[addr] = 0;
            OP_FLUSH: begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
                m_hits = 0;
                m_misses = 0;
            end
            OP_CMP: begin
                hits_found = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_valid[i] && (((key ^ m_key[i]) & m_mask[i] & mask) == 8'h00)) begin
                        if (hits_found == 0) begin
                            e_index = i;
                            e_res   = m_res[i];
                        end
                        hits_found++;
                    end
                end
                e_hit   = (hits_found >= 1);
                e_multi = (hits_found >= 2);
                if (e_hit) begin
                    if (m_hits < 16'hFFFF) m_hits++;
                end else begin
                    if (m_misses < 16'hFFFF) m_misses++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_rsp(input string tag);
        check({tag, "_op"},    32'(bus.rsp_op),          32'(e_op));
        check({tag, "_err"},   32'(bus.rsp_err),         32'(e_err));
        check({tag, "_hit"},   32'(bus.rsp_hit),         32'(e_hit));
        check({tag, "_multi"}, 32'(bus.rsp_multi),       32'(e_multi));
        check({tag, "_index"}, 32'(bus.rsp_index),       32'(e_index));
        check({tag, "_ev"},    32'(bus.rsp_entry_valid), 32'(e_ev));
        if (!e_dc) begin
            check({tag, "_key"},    32'(bus.rsp_key),    32'(e_key));
            check({tag, "_mask"},   32'(bus.rsp_mask),   32'(e_mask));
            check({tag, "_result"}, 32'(bus.rsp_result), 32'(e_res));
        end
`ifdef TCAM_HIT_STATS_EN
        check({tag, "_stat_hits"},   32'(stat_hits),   32'(m_hits));
        check({tag, "_stat_misses"}, 32'(stat_misses), 32'(m_misses));
`endif
    endtask

    // ---------------- one command, full handshake ----------------
    task automatic issue(input logic [2:0] op, input int addr, input logic [7:0] key,
                         input logic [7:0] mask, input logic [3:0] res, input int hold);
        int budget;
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr   = ADDR_W'(addr);
        bus.cmd_key    = key;
        bus.cmd_mask   = mask;
        bus.cmd_result = res;
        budget = 0;
        while (!bus.cmd_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);                 // accept edge N
        model_exec(op, addr, key, mask, res);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("lat_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("lat_exec_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);                 // after edge N+1: response visible at edge N+2
        check("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check_rsp("hold");
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_ready", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        check_rsp("rsp");
        $display("txn %0d op=%0d addr=%0d key=%02h mask=%02h res=%0h -> err=%0d hit=%0d multi=%0d idx=%0d result=%0h",
                 n_txn, op, addr, key, mask, res, bus.rsp_err, bus.rsp_hit, bus.rsp_multi,
                 bus.rsp_index, bus.rsp_result);
        n_txn++;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_hs_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [7:0] key_pool [4];
    logic [7:0] rkey, rmask;
    logic [2:0] rop;

    initial begin
        key_pool[0] = 8'hA5; key_pool[1] = 8'hA0; key_pool[2] = 8'h3C; key_pool[3] = 8'h5A;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0;
        bus.cmd_key = '0; bus.cmd_mask = '0; bus.cmd_result = '0;
        bus.rsp_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        e_op = 0; e_err = 0; e_hit = 0; e_multi = 0; e_ev = 0; e_dc = 0;
        e_index = 0; e_key = 0; e_mask = 0; e_res = 0;
        check_rsp("reset");
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_ready", 32'(bus.cmd_ready), 32'd1);

        // Single exact-match lookup
        issue(OP_WRITE, 3, 8'hA5, 8'hFF, 4'h7, 0);
        issue(OP_CMP,   0, 8'hA5, 8'hFF, 4'h0, 0);

        // Priority / multi-hit, then invalidate the winner
        issue(OP_FLUSH, 0, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_WRITE, 2, 8'hA0, 8'hF0, 4'h1, 0);
        issue(OP_WRITE, 5, 8'hA5, 8'hFF, 4'h2, 0);
        issue(OP_CMP,   0, 8'hA5, 8'hFF, 4'h0, 0);
        issue(OP_INV,   2, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_CMP,   0, 8'hA5, 8'hFF, 4'h0, 0);

        // Search mask 0 matches every valid entry; then flush -> miss
        issue(OP_WRITE, 7, 8'h11, 8'hFF, 4'h3, 0);
        issue(OP_WRITE, 1, 8'h22, 8'hFF, 4'h4, 0);
        issue(OP_WRITE, 9, 8'h33, 8'h0F, 4'h5, 0);
        issue(OP_CMP,   0, 8'h3C, 8'h00, 4'h0, 0);
        issue(OP_FLUSH, 0, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_CMP,   0, 8'h3C, 8'h00, 4'h0, 0);

        // Backpressure: response held 5 cycles
        issue(OP_WRITE, 4, 8'hC3, 8'hFF, 4'h9, 0);
        issue(OP_CMP,   0, 8'hC3, 8'hFF, 4'h0, 5);

        // Errors and address boundaries
        issue(OP_WRITE, 0, 8'h5A, 8'hFF, 4'hE, 0);
        issue(OP_READ,  13, 8'h00, 8'h00, 4'h0, 0);
        issue(3'b111,   0, 8'hFF, 8'hFF, 4'hF, 0);
        issue(3'b110,   0, 8'hFF, 8'hFF, 4'hF, 0);
        issue(OP_WRITE, 12, 8'hFF, 8'hFF, 4'hF, 0);
        issue(OP_INV,   15, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_READ,  0, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_WRITE, 11, 8'h77, 8'hF0, 4'hB, 0);
        issue(OP_READ,  11, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_NOP,   6, 8'hFF, 8'hFF, 4'hF, 0);

        // Reset while a WRITE is in EXEC: no response, entry stays invalid
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_addr = ADDR_W'(7);
        bus.cmd_key = 8'h99; bus.cmd_mask = 8'hFF; bus.cmd_result = 4'h6;
        check("rstexec_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstexec_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("rstexec_valid_low", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rstexec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        issue(OP_READ, 7, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_CMP,  0, 8'h99, 8'hFF, 4'h0, 0);

        // Statistics: 3 hits + 2 misses from a clean count
        issue(OP_FLUSH, 0, 8'h00, 8'h00, 4'h0, 0);
        issue(OP_WRITE, 2, 8'h10, 8'hFF, 4'h1, 0);
        issue(OP_CMP,   0, 8'h10, 8'hFF, 4'h0, 0);
        issue(OP_CMP,   0, 8'h11, 8'hFF, 4'h0, 0);
        issue(OP_CMP,   0, 8'h11, 8'hFE, 4'h0, 0);
        issue(OP_CMP,   0, 8'h20, 8'hFF, 4'h0, 0);
        issue(OP_CMP,   0, 8'h10, 8'hF0, 4'h0, 0);
`ifdef TCAM_HIT_STATS_EN
        check("stat_hits_3",   32'(stat_hits),   32'd3);
        check("stat_misses_2", 32'(stat_misses), 32'd2);
`endif

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rop = OP_WRITE;
                3, 4, 5: rop = OP_CMP;
                6:       rop = OP_READ;
                7:       rop = OP_INV;
                8:       rop = ($urandom_range(0, 3) == 0) ? OP_FLUSH : OP_NOP;
                default: rop = 3'($urandom_range(6, 7));
            endcase
            rkey = key_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rkey = rkey ^ 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rmask = 8'hFF;
                1:       rmask = 8'hF0;
                2:       rmask = 8'h0F;
                default: rmask = 8'($urandom_range(0, 255));
            endcase
            issue(rop, $urandom_range(0, 15), rkey, rmask, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
